// File: rtl/hc595_led7seg_receiver_pkg.sv
// Shared types and constants for the 74HC595 LED7seg link receiver and display drivers.
package hc595_rx_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned SEL_W  = 8;

    // Active-low segment patterns {a,b,c,d,e,f,g} for digits 0..9.
    localparam logic [6:0] SEG_PAT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic logic [3:0] seg2bcd(input logic [6:0] seg);
        seg2bcd = 4'hF;
        for (int unsigned i = 0; i < 10; i++) begin
            if (seg == SEG_PAT[i]) seg2bcd = 4'(i);
        end
    endfunction

endpackage

// File: rtl/hc595_led7seg_receiver_if.sv
// Serial display link (shift clock, storage clock, data) between a 595 driver and a receiver.
interface hc595_led7seg_receiver_if;
    logic sclk_i;
    logic rclk_i;
    logic dio_i;

    modport master (output sclk_i, output rclk_i, output dio_i);
    modport slave  (input  sclk_i, input  rclk_i, input  dio_i);
endinterface

// File: rtl/hc595_led7seg_receiver_sync_edge.sv
// N-stage synchronizer with a one-cycle rising-edge pulse on the synchronized level.
module hc595_rx_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/hc595_led7seg_receiver.sv
// Receiver end of the 595 LED7seg link: two cascaded 595s emulated in the clk domain plus digit decode.
// Optional BCD decode of each written digit is enabled by defining HC595_RX_BCD_DECODE_EN.
module hc595_led7seg_receiver
    import hc595_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    hc595_led7seg_receiver_if.slave     link,
    output logic [WORD_W-1:0]           frm_dat,
    output logic                        frm_vld,
    output logic [SEG_W*NUM_DIGITS-1:0] seg_flat,
    output logic [NUM_DIGITS-1:0]       dig_upd,
    output logic [15:0]                 frm_cnt,
    output logic                        len_err,
    output logic                        sel_err,
    output logic                        tmo_err
`ifdef HC595_RX_BCD_DECODE_EN
    ,
    output logic [4*NUM_DIGITS-1:0]     bcd_flat,
    output logic                        pat_err
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic                   sclk_rise;
    logic                   rclk_rise;
    logic [SYNC_STAGES-1:0] dio_pipe;
    logic                   dio_sync;

    state_t                 state;
    state_t                 next_state;
    logic [WORD_W-1:0]      sh;
    logic [4:0]             bitcnt;
    logic [TW-1:0]          idle_cnt;
    logic                   timeout;

    logic                   latch_now;
    logic                   sel_ok;
    logic [NUM_DIGITS-1:0]  wr_mask;
    logic [3:0]             bcd_val;

    hc595_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (link.sclk_i),
        .rise (sclk_rise)
    );

    hc595_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_rclk (
        .clk  (clk),
        .rst  (rst),
        .d    (link.rclk_i),
        .rise (rclk_rise)
    );

    // Same depth as the clock synchronizers so dio lines up with the sclk edge it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dio_pipe <= '0;
        else     dio_pipe <= {dio_pipe[SYNC_STAGES-2:0], link.dio_i};
    end
    assign dio_sync = dio_pipe[SYNC_STAGES-1];

    assign timeout = (state == SHIFT) && !sclk_rise && !rclk_rise &&
                     (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rclk_rise)      next_state = LATCH;
                else if (sclk_rise) next_state = SHIFT;
            end
            SHIFT: begin
                if (rclk_rise)    next_state = LATCH;
                else if (timeout) next_state = IDLE;
            end
            LATCH:   next_state = sclk_rise ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        latch_now = (state == LATCH);
        sel_ok    = $onehot(sh[SEL_W-1:0]) && (sh[NUM_DIGITS-1:0] != '0);
        wr_mask   = sel_ok ? sh[NUM_DIGITS-1:0] : '0;
        bcd_val   = seg2bcd(sh[WORD_W-2 -: 7]);
    end

    // A same-cycle sclk rise is shifted before LATCH captures sh, so it is always counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            bitcnt   <= '0;
            idle_cnt <= '0;
            frm_dat  <= '0;
            frm_vld  <= 1'b0;
            seg_flat <= '0;
            dig_upd  <= '0;
            frm_cnt  <= '0;
            len_err  <= 1'b0;
            sel_err  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            if (sclk_rise) sh <= {sh[WORD_W-2:0], dio_sync};

            if (latch_now || timeout)
                bitcnt <= sclk_rise ? 5'd1 : 5'd0;
            else if (sclk_rise && bitcnt != 5'd31)
                bitcnt <= bitcnt + 5'd1;

            if (state != SHIFT || sclk_rise || timeout) idle_cnt <= '0;
            else                                       idle_cnt <= idle_cnt + TW'(1);

            frm_vld <= latch_now;
            len_err <= latch_now && (bitcnt != 5'd16);
            sel_err <= latch_now && !sel_ok;
            dig_upd <= latch_now ? wr_mask : '0;
            tmo_err <= timeout;

            if (latch_now) begin
                frm_dat <= sh;
                frm_cnt <= frm_cnt + 16'd1;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_mask[i]) seg_flat[SEG_W*i +: SEG_W] <= sh[WORD_W-1 -: SEG_W];
                end
            end
        end
    end

`ifdef HC595_RX_BCD_DECODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_flat <= '0;
            pat_err  <= 1'b0;
        end else begin
            pat_err <= latch_now && sel_ok && (bcd_val == 4'hF);
            if (latch_now) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_mask[i]) bcd_flat[4*i +: 4] <= bcd_val;
                end
            end
        end
    end
`else
    logic unused_bcd;
    assign unused_bcd = ^bcd_val;
`endif

endmodule
